// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage core.
// It drives the stage-register enables and flushes for PC, IF/ID, ID/EX and EX/MEM,
// generates the operand-forwarding selects, and counts cycles spent with the PC frozen.
// Ports:
//   clk_i, reset_i        clock (rising edge), asynchronous active-low reset
//   id_*_i                source registers and use flags of the instruction in ID
//   ex_*_i                destination and class flags of the instruction in EX
//   mem_*_i               destination and write flag of the instruction in MEM
//   mem_busy_i            data memory not ready this cycle
//   *_en_o, *_flush_o     stage register enables / bubble loads (flush overrides enable)
//   fwd_a_o, fwd_b_o      00 regfile, 01 EX result, 10 MEM result
//   state_o               00 RUN, 01 LU_STALL, 10 STACK_WAIT
//   stall_cycles_o        saturating count of cycles with pc_en_o low
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned STACK_LAT  = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_stack_op_i,
  input  logic                  ex_redirect_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_reg_write_i,
  input  logic                  mem_busy_i,
  output logic                  pc_en_o,
  output logic                  ifid_en_o,
  output logic                  idex_en_o,
  output logic                  exmem_en_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  // Counter must hold STACK_LAT-1.
  localparam int unsigned STK_W = (STACK_LAT > 2) ? $clog2(STACK_LAT) : 1;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LU_STALL   = 2'b01,
    STACK_WAIT = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [STK_W-1:0] cnt_q, cnt_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic load_use_c;
  logic release_c;
  logic freeze_c;

  assign load_use_c = ex_is_load_i & ex_reg_write_i &
                      ((id_uses_rs_i & (ex_rd_i == id_rs_i)) |
                       (id_uses_rt_i & (ex_rd_i == id_rt_i)));

  // Release cycle of a stack op: cnt reached 1 in STACK_WAIT, or the
  // single-cycle release flag used when STACK_LAT == 2.
  assign release_c = ((state_q == STACK_WAIT) && (cnt_q == STK_W'(1))) ||
                     ((state_q == RUN) && rel_q);

  // Next state and stage controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rel_d        = rel_q;
    freeze_c     = 1'b0;
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    idex_en_o    = 1'b1;
    exmem_en_o   = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;

    if (mem_busy_i) begin
      freeze_c = 1'b1;
    end else if (release_c) begin
      // Redirect of the stack op itself is applied on the way out.
      ifid_flush_o = ex_redirect_i;
      idex_flush_o = ex_redirect_i;
      cnt_d        = '0;
      rel_d        = 1'b0;
      state_d      = RUN;
    end else if (state_q == STACK_WAIT) begin
      freeze_c = 1'b1;
      cnt_d    = cnt_q - STK_W'(1);
    end else begin
      state_d = RUN;
      if (ex_stack_op_i && (STACK_LAT > 1)) begin
        freeze_c = 1'b1;
        cnt_d    = STK_W'(STACK_LAT - 1);
        if (STACK_LAT == 2) begin
          rel_d = 1'b1;
        end else begin
          state_d = STACK_WAIT;
        end
      end else if (ex_redirect_i) begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
      end else if (load_use_c && (state_q == RUN)) begin
        pc_en_o      = 1'b0;
        ifid_en_o    = 1'b0;
        idex_flush_o = 1'b1;
        state_d      = LU_STALL;
      end
    end

    if (freeze_c) begin
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
    end

    // Held in reset: nothing advances, bubbles are loaded.
    if (!reset_i) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_en_o    = 1'b0;
      exmem_en_o   = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end
  end

  // Forwarding selects; loads are not forwardable from EX.
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (reset_i) begin
      if (ex_reg_write_i && !ex_is_load_i && (ex_rd_i == id_rs_i)) begin
        fwd_a_o = 2'b01;
      end else if (mem_reg_write_i && (mem_rd_i == id_rs_i)) begin
        fwd_a_o = 2'b10;
      end
      if (ex_reg_write_i && !ex_is_load_i && (ex_rd_i == id_rt_i)) begin
        fwd_b_o = 2'b01;
      end else if (mem_reg_write_i && (mem_rd_i == id_rt_i)) begin
        fwd_b_o = 2'b10;
      end
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_d = stall_q;
    if (!pc_en_o && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      stall_q <= stall_d;
    end
  end

  assign state_o        = state_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. A second instance with a 2-bit
// stall counter shares the stimulus to exercise counter saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [2:0] id_rs_i, id_rt_i, ex_rd_i, mem_rd_i;
  logic       id_uses_rs_i, id_uses_rt_i;
  logic       ex_reg_write_i, ex_is_load_i, ex_stack_op_i, ex_redirect_i;
  logic       mem_reg_write_i, mem_busy_i;

  logic        pc_en_o, ifid_en_o, idex_en_o, exmem_en_o;
  logic        ifid_flush_o, idex_flush_o;
  logic [1:0]  fwd_a_o, fwd_b_o, state_o;
  logic [15:0] stall_cycles_o;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en;
  logic        s_ifid_flush, s_idex_flush;
  logic [1:0]  s_fwd_a, s_fwd_b, s_state;
  logic [1:0]  s_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl u_dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_is_load_i(ex_is_load_i), .ex_stack_op_i(ex_stack_op_i),
    .ex_redirect_i(ex_redirect_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
    .mem_busy_i(mem_busy_i),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .idex_en_o(idex_en_o),
    .exmem_en_o(exmem_en_o), .ifid_flush_o(ifid_flush_o),
    .idex_flush_o(idex_flush_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .state_o(state_o), .stall_cycles_o(stall_cycles_o)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_is_load_i(ex_is_load_i), .ex_stack_op_i(ex_stack_op_i),
    .ex_redirect_i(ex_redirect_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
    .mem_busy_i(mem_busy_i),
    .pc_en_o(s_pc_en), .ifid_en_o(s_ifid_en), .idex_en_o(s_idex_en),
    .exmem_en_o(s_exmem_en), .ifid_flush_o(s_ifid_flush),
    .idex_flush_o(s_idex_flush), .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b),
    .state_o(s_state), .stall_cycles_o(s_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs_i = '0; id_rt_i = '0; ex_rd_i = '0; mem_rd_i = '0;
    id_uses_rs_i = 1'b0; id_uses_rt_i = 1'b0;
    ex_reg_write_i = 1'b0; ex_is_load_i = 1'b0;
    ex_stack_op_i = 1'b0; ex_redirect_i = 1'b0;
    mem_reg_write_i = 1'b0; mem_busy_i = 1'b0;
  endtask

  // Enables as {pc, ifid, idex, exmem}, flushes as {ifid, idex}.
  task automatic check_stage(input string tag, input logic [3:0] en, input logic [1:0] fl);
    check_eq({tag, "_en"}, {28'd0, pc_en_o, ifid_en_o, idex_en_o, exmem_en_o}, {28'd0, en});
    check_eq({tag, "_fl"}, {30'd0, ifid_flush_o, idex_flush_o}, {30'd0, fl});
  endtask

  initial begin
    clear_inputs();
    reset_i = 1'b0;
    #2;
    check_stage("rst", 4'b0000, 2'b11);
    check_eq("rst_stall", 32'(stall_cycles_o), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_fwd", {28'd0, fwd_a_o, fwd_b_o}, 32'd0);
    repeat (3) tick();
    check_eq("rst_hold_stall", 32'(stall_cycles_o), 32'd0);
    reset_i = 1'b1;
    #1;
    check_stage("run", 4'b1111, 2'b00);
    check_eq("run_state", 32'(state_o), 32'd0);

    // Load-use on rs.
    ex_is_load_i = 1'b1; ex_reg_write_i = 1'b1; ex_rd_i = 3'd3;
    id_rs_i = 3'd3; id_uses_rs_i = 1'b1;
    #1;
    check_stage("lu", 4'b0011, 2'b01);
    check_eq("lu_fwd_a", 32'(fwd_a_o), 32'd0);
    tick();
    check_eq("lu_state", 32'(state_o), 32'd1);
    check_eq("lu_stall", 32'(stall_cycles_o), 32'd1);
    ex_is_load_i = 1'b0; ex_reg_write_i = 1'b0;
    mem_rd_i = 3'd3; mem_reg_write_i = 1'b1;
    #1;
    check_stage("lu2", 4'b1111, 2'b00);
    check_eq("lu2_fwd_a", 32'(fwd_a_o), 32'd2);
    tick();
    check_eq("lu2_state", 32'(state_o), 32'd0);
    check_eq("lu2_stall", 32'(stall_cycles_o), 32'd1);
    check_eq("sat_1", 32'(s_stall), 32'd1);

    // Forwarding priority on rt, then on rs.
    clear_inputs();
    ex_reg_write_i = 1'b1; ex_rd_i = 3'd5;
    mem_reg_write_i = 1'b1; mem_rd_i = 3'd5; id_rt_i = 3'd5;
    #1;
    check_eq("fwd_b_ex", 32'(fwd_b_o), 32'd1);
    check_eq("fwd_a_none", 32'(fwd_a_o), 32'd0);
    ex_rd_i = 3'd2;
    #1;
    check_eq("fwd_b_mem", 32'(fwd_b_o), 32'd2);
    mem_reg_write_i = 1'b0;
    #1;
    check_eq("fwd_b_rf", 32'(fwd_b_o), 32'd0);
    id_rs_i = 3'd2;
    #1;
    check_eq("fwd_a_ex", 32'(fwd_a_o), 32'd1);
    check_stage("fwd", 4'b1111, 2'b00);

    // Stack op with redirect held: two frozen cycles, release flushes.
    clear_inputs();
    ex_stack_op_i = 1'b1; ex_redirect_i = 1'b1;
    #1;
    check_stage("stk1", 4'b0000, 2'b00);
    tick();
    check_eq("stk1_state", 32'(state_o), 32'd2);
    check_stage("stk2", 4'b0000, 2'b00);
    tick();
    check_eq("stk2_state", 32'(state_o), 32'd2);
    check_stage("stk3", 4'b1111, 2'b11);
    tick();
    clear_inputs();
    #1;
    check_eq("stk_done_state", 32'(state_o), 32'd0);
    check_eq("stk_stall", 32'(stall_cycles_o), 32'd3);
    check_eq("sat_3", 32'(s_stall), 32'd3);

    // mem_busy during STACK_WAIT with cnt = 2.
    ex_stack_op_i = 1'b1;
    #1;
    check_stage("sb_trig", 4'b0000, 2'b00);
    tick();
    mem_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_stage($sformatf("sb_busy%0d", i), 4'b0000, 2'b00);
      check_eq($sformatf("sb_busy_state%0d", i), 32'(state_o), 32'd2);
      tick();
    end
    mem_busy_i = 1'b0;
    #1;
    check_stage("sb_cnt2", 4'b0000, 2'b00);
    tick();
    check_stage("sb_rel", 4'b1111, 2'b00);
    tick();
    clear_inputs();
    #1;
    check_eq("sb_state", 32'(state_o), 32'd0);
    check_eq("sb_stall", 32'(stall_cycles_o), 32'd9);
    check_eq("sat_hold", 32'(s_stall), 32'd3);

    // Redirect beats load-use.
    ex_redirect_i = 1'b1; ex_is_load_i = 1'b1; ex_reg_write_i = 1'b1;
    ex_rd_i = 3'd4; id_rt_i = 3'd4; id_uses_rt_i = 1'b1;
    #1;
    check_stage("rdlu", 4'b1111, 2'b11);
    check_eq("rdlu_fwd_b", 32'(fwd_b_o), 32'd0);
    tick();
    check_eq("rdlu_state", 32'(state_o), 32'd0);
    check_eq("rdlu_stall", 32'(stall_cycles_o), 32'd9);

    // Plain mem_busy freeze in RUN for 3 cycles.
    clear_inputs();
    mem_busy_i = 1'b1;
    #1;
    check_stage("busy", 4'b0000, 2'b00);
    repeat (3) tick();
    check_eq("busy_state", 32'(state_o), 32'd0);
    check_eq("busy_stall", 32'(stall_cycles_o), 32'd12);
    check_eq("sat_final", 32'(s_stall), 32'd3);
    mem_busy_i = 1'b0;

    // Reset mid-STACK_WAIT discards the countdown.
    ex_stack_op_i = 1'b1;
    tick();
    check_eq("mid_state", 32'(state_o), 32'd2);
    clear_inputs();
    reset_i = 1'b0;
    #1;
    check_eq("mid_rst_state", 32'(state_o), 32'd0);
    check_stage("mid_rst", 4'b0000, 2'b11);
    check_eq("mid_rst_stall", 32'(stall_cycles_o), 32'd0);
    tick();
    reset_i = 1'b1;
    #1;
    check_stage("post_rst", 4'b1111, 2'b00);
    tick();
    check_eq("post_rst_state", 32'(state_o), 32'd0);
    check_stage("post_rst2", 4'b1111, 2'b00);
    check_eq("post_rst_stall", 32'(stall_cycles_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage pipelined 19-bit-instruction core.
- Sits beside the instruction-decode controller and drives the per-stage register enables and flushes for PC, IF/ID, ID/EX and EX/MEM.
- Detects load-use hazards, serialises multi-cycle stack operations (JSB push / RET pop), flushes wrong-path instructions on redirect (taken branch, JMP, JSB, RET resolved in EX), and freezes the pipeline on data-memory busy.
- Also produces operand-forwarding selects and a saturating stall-cycle counter.

Parameters:
- REG_ADDR_W, 3: register-number width (8 registers, none hardwired; all forwardable).
- STACK_LAT, 3: cycles a stack op occupies EX (≥1); 1 = no stall.
- CNT_W, 16: stall_cycles width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  REG_ADDR_W  source registers of instruction in ID.
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt.
- ex_rd  in  REG_ADDR_W  destination of instruction in EX.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is LDM.
- ex_stack_op  in  1  EX instruction is JSB or RET.
- ex_redirect  in  1  EX instruction changes PC (pc_mux ≠ 0).
- mem_rd  in  REG_ADDR_W  destination of instruction in MEM.
- mem_reg_write  in  1  MEM instruction writes a register.
- mem_busy  in  1  data memory not ready this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1  stage register enables.
- ifid_flush, idex_flush  out  1  load bubble into IF/ID / ID/EX (flush overrides enable).
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 EX result, 10 MEM result.
- state  out  2  00 RUN, 01 LU_STALL, 10 STACK_WAIT.
- stall_cycles  out  CNT_W  cycles with pc_en = 0.

Behaviour:
- Reset (reset = 0, async):
  - state = RUN, internal down-counter cnt = 0, stall_cycles = 0.
  - Outputs forced: all enables 0, both flushes 1, fwd_a = fwd_b = 00.
- Stage outputs are combinational from state, cnt and inputs; state, cnt and stall_cycles update on the rising clk edge.
- load_use = ex_is_load & ex_reg_write & ((id_uses_rs & ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- Forwarding (all states):
  - fwd_a = 01 if ex_reg_write & !ex_is_load & ex_rd == id_rs.
  - Else fwd_a = 10 if mem_reg_write & mem_rd == id_rs.
  - Else fwd_a = 00. EX has priority over MEM. fwd_b is identical using id_rt.
- Default action ("advance"): all enables 1, flushes 0.
- Priority in RUN, highest first:
  1. mem_busy: all enables 0, flushes 0; state and cnt hold.
  2. ex_stack_op & STACK_LAT > 1: all enables 0; cnt <= STACK_LAT-1; if STACK_LAT == 2, state <= RUN with a release next cycle, tracked by a single internal flag; otherwise state <= STACK_WAIT.
  3. ex_redirect: advance plus ifid_flush = idex_flush = 1.
  4. load_use: pc_en = ifid_en = 0, idex_en = exmem_en = 1, idex_flush = 1; state <= LU_STALL.
  5. Otherwise: advance.
- LU_STALL: the load is now in MEM (fwd selects 10). Same evaluation as RUN except load_use is ignored; state <= RUN unless mem_busy (hold).
- STACK_WAIT:
  - mem_busy: freeze and hold.
  - cnt > 1: all enables 0, cnt <= cnt-1.
  - cnt == 1 (release cycle): advance; if ex_redirect, both flushes = 1 (RET/JSB redirect); cnt <= 0, state <= RUN. The stack op is not re-triggered.
- Net effect: a stack op freezes EX for STACK_LAT-1 cycles and leaves EX in cycle STACK_LAT.
- Simultaneous events: mem_busy beats everything. Stack op beats redirect (redirect is applied at release). Redirect beats load_use (ID is wrong-path).
- stall_cycles: +1 on every clock edge with reset high and pc_en == 0; saturates at all-ones; cleared only by reset.
- Reset asserted mid-STACK_WAIT or mid-LU_STALL: returns to RUN immediately; the counter is discarded.

Test Plan:
- Reset low 3 cycles, then high with all inputs 0 -> during reset: enables 0, flushes 1, stall_cycles 0; after release: state 00, all enables 1, flushes 0.
- ex_is_load = 1, ex_reg_write = 1, ex_rd = 3, id_rs = 3, id_uses_rs = 1 -> one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1, state -> 01. Next cycle (ex_is_load = 0, mem_rd = 3, mem_reg_write = 1): advance, fwd_a = 10, state 00, stall_cycles = 1.
- ex_reg_write = 1, ex_rd = 5, mem_reg_write = 1, mem_rd = 5, id_rt = 5 -> fwd_b = 01 (EX priority). ex_rd = 2 -> fwd_b = 10. mem_reg_write = 0 -> fwd_b = 00.
- ex_stack_op = 1, ex_redirect = 1 held, STACK_LAT = 3 -> cycles 1-2: all enables 0, state 10 in cycle 2. Cycle 3: enables 1, ifid_flush = idex_flush = 1, then state 00. stall_cycles += 2.
- mem_busy = 1 for 4 cycles during STACK_WAIT with cnt = 2 -> enables 0 and cnt held at 2 throughout; release occurs 2 cycles after mem_busy drops; stall_cycles counts all frozen cycles.
- ex_redirect = 1 together with load_use = 1 -> flushes both 1, all enables 1, state stays 00. Also force stall_cycles to 16'hFFFE and freeze 3 cycles -> saturates at 16'hFFFF.
